ncu_mcu_link_chk: RTL and testbench

//  Synthesizable, parametrised protocol checker for the NCU<->MCU 4-bit serial UCB links.

---
 rtl/ncu_mcu_link_chk.sv | 220 ++++++++++++++++++++++
 tb/tb_ncu_mcu_link_chk.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ncu_mcu_link_chk.sv
// rtl/ncu_mcu_link_chk.sv - NCU<->MCU UCB serial link protocol checker
module ncu_mcu_link_chk #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 4,
  parameter int HDR_BEATS = 16,
  parameter int PLD_BEATS = 16,
  parameter int STALL_LAT = 2,
  parameter int CNT_W     = 16
) (
  input  logic                     iol2clk,
  input  logic                     rst_l,
  input  logic                     enable,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        ch_vld,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_stall,
  output logic [NUM_CH*CNT_W-1:0]  pkt_cnt,
  output logic                     err_vld,
  output logic [2:0]               err_ch,
  output logic [1:0]               err_code,
  output logic [NUM_CH-1:0]        err_sticky
);

  localparam int MAX_BEATS = (HDR_BEATS > PLD_BEATS) ? HDR_BEATS : PLD_BEATS;
  localparam int BC_W      = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_GAP   = 2'd1;
  localparam logic [1:0] CODE_STALL = 2'd2;
  localparam logic [1:0] CODE_SAT   = 2'd3;

  localparam logic [BC_W-1:0] HDR_LAST = BC_W'(HDR_BEATS - 1);
  localparam logic [BC_W-1:0] PLD_LAST = BC_W'(PLD_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PLD  = 2'd2
  } state_e;

  // Per-channel violation code for the current cycle, CODE_NONE when clean.
  logic [1:0] ch_code [NUM_CH];

  // Only bit 0 of the first header beat matters; the rest of the bus is ignored.
  logic unused_data;
  assign unused_data = ^ch_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

    state_e               state_q, state_d;
    logic [BC_W-1:0]      bc_q, bc_d;
    logic                 wr_q, wr_d;
    logic [STALL_LAT-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    logic complete;
    logic gap;
    logic stall_start;
    logic sat;
    logic any_err;

    // Framing FSM, beat counter, write flag and stall history registers.
    always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
        state_q <= ST_IDLE;
        bc_q    <= '0;
        wr_q    <= 1'b0;
        hist_q  <= '0;
      end else begin
        state_q <= state_d;
        bc_q    <= bc_d;
        wr_q    <= wr_d;
        hist_q  <= hist_d;
      end
    end

    // Next-state: track header/payload beats, detect gaps and starts after a long stall.
    always_comb begin
      state_d     = state_q;
      bc_d        = bc_q;
      wr_d        = wr_q;
      hist_d      = STALL_LAT'({hist_q, ch_stall[g]});
      complete    = 1'b0;
      gap         = 1'b0;
      stall_start = 1'b0;
      if (!enable) begin
        // Disabled: drop any packet in flight and forget recent stall activity.
        state_d = ST_IDLE;
        bc_d    = '0;
        hist_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ch_vld[g]) begin
              // hist_q holds the stall values of the STALL_LAT cycles before this start.
              stall_start = &hist_q;
              wr_d        = ch_data[g*DATA_W];
              bc_d        = BC_W'(1);
              state_d     = ST_HDR;
            end
          end
          ST_HDR: begin
            if (!ch_vld[g]) begin
              gap     = 1'b1;
              state_d = ST_IDLE;
              bc_d    = '0;
            end else if (bc_q == HDR_LAST) begin
              bc_d = '0;
              if (wr_q) begin
                state_d = ST_PLD;
              end else begin
                complete = 1'b1;
                state_d  = ST_IDLE;
              end
            end else begin
              bc_d = bc_q + BC_W'(1);
            end
          end
          ST_PLD: begin
            if (!ch_vld[g]) begin
              gap     = 1'b1;
              state_d = ST_IDLE;
              bc_d    = '0;
            end else if (bc_q == PLD_LAST) begin
              complete = 1'b1;
              state_d  = ST_IDLE;
              bc_d     = '0;
            end else begin
              bc_d = bc_q + BC_W'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            bc_d    = '0;
          end
        endcase
      end
    end

    assign sat     = complete & (&cnt_q);
    assign any_err = gap | stall_start | sat;

    // Single code per channel; gap outranks stall-start, which outranks saturation.
    assign ch_code[g] = gap         ? CODE_GAP   :
                        stall_start ? CODE_STALL :
                        sat         ? CODE_SAT   : CODE_NONE;

    // Packet counter and sticky flag; a same-cycle event beats a clear.
    always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (clr) begin
        cnt_d    = '0;
        sticky_d = 1'b0;
      end
      if (complete) begin
        if (clr) begin
          cnt_d = CNT_W'(1);
        end else if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (any_err) begin
        sticky_d = 1'b1;
      end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge iol2clk or negedge rst_l) begin
      if (!rst_l) begin
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        sticky_q <= sticky_d;
      end
    end

    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q;
    assign err_sticky[g]             = sticky_q;

  end : g_ch

  logic       err_vld_q, err_vld_d;
  logic [2:0] err_ch_q, err_ch_d;
  logic [1:0] err_code_q, err_code_d;

  // Pick the lowest-numbered channel reporting a violation this cycle.
  always_comb begin
    err_vld_d  = 1'b0;
    err_ch_d   = err_ch_q;
    err_code_d = err_code_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_code[i] != CODE_NONE) begin
        err_vld_d  = 1'b1;
        err_ch_d   = 3'(i);
        err_code_d = ch_code[i];
      end
    end
  end

  // Registered violation report, one cycle after the offending beat.
  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      err_vld_q  <= 1'b0;
      err_ch_q   <= 3'd0;
      err_code_q <= 2'd0;
    end else begin
      err_vld_q  <= err_vld_d;
      err_ch_q   <= err_ch_d;
      err_code_q <= err_code_d;
    end
  end

  assign err_vld  = err_vld_q;
  assign err_ch   = err_ch_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_ncu_mcu_link_chk.sv
// tb/tb_ncu_mcu_link_chk.sv - self-checking bench for ncu_mcu_link_chk
`timescale 1ns/1ps
module tb_ncu_mcu_link_chk;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int HDR    = 16;
  localparam int PLD    = 16;
  localparam int SLAT   = 2;
  localparam int CNT_W  = 16;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic                     iol2clk = 1'b0;
  logic                     rst_l   = 1'b0;
  logic                     rst_s   = 1'b0;
  logic                     enable  = 1'b0;
  logic                     clr     = 1'b0;
  logic [NUM_CH-1:0]        ch_vld  = '0;
  logic [NUM_CH-1:0]        ch_stall = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;

  logic [NUM_CH*CNT_W-1:0]  pkt_cnt;
  logic                     err_vld;
  logic [2:0]               err_ch;
  logic [1:0]               err_code;
  logic [NUM_CH-1:0]        err_sticky;

  logic [NUM_CH*2-1:0]      pkt_cnt_s;
  logic                     err_vld_s;
  logic [2:0]               err_ch_s;
  logic [1:0]               err_code_s;
  logic [NUM_CH-1:0]        err_sticky_s;

  ncu_mcu_link_chk #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HDR_BEATS(HDR), .PLD_BEATS(PLD),
                     .STALL_LAT(SLAT), .CNT_W(CNT_W)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l), .enable(enable), .clr(clr),
    .ch_vld(ch_vld), .ch_data(ch_data), .ch_stall(ch_stall),
    .pkt_cnt(pkt_cnt), .err_vld(err_vld), .err_ch(err_ch), .err_code(err_code),
    .err_sticky(err_sticky)
  );

  ncu_mcu_link_chk #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .HDR_BEATS(HDR), .PLD_BEATS(PLD),
                     .STALL_LAT(SLAT), .CNT_W(2)) dut_s (
    .iol2clk(iol2clk), .rst_l(rst_s), .enable(enable), .clr(clr),
    .ch_vld(ch_vld), .ch_data(ch_data), .ch_stall(ch_stall),
    .pkt_cnt(pkt_cnt_s), .err_vld(err_vld_s), .err_ch(err_ch_s), .err_code(err_code_s),
    .err_sticky(err_sticky_s)
  );

  always #5 iol2clk = ~iol2clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model of the main instance: beats seen in the current packet, its length,
  // consecutive stall cycles, counts and the expected report.
  int              m_pos  [NUM_CH];
  int              m_len  [NUM_CH];
  int              m_srun [NUM_CH];
  int              m_cnt  [NUM_CH];
  bit [NUM_CH-1:0] m_sticky;
  bit              m_err_vld;
  int              m_err_ch;
  int              m_err_code;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pos[c] = 0; m_len[c] = 0; m_srun[c] = 0; m_cnt[c] = 0;
    end
    m_sticky = '0; m_err_vld = 0; m_err_ch = 0; m_err_code = 0;
  endtask

  task automatic model_update();
    bit found;
    bit done;
    int code;
    found     = 0;
    m_err_vld = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      code = 0;
      done = 0;
      if (!enable) begin
        m_pos[c]  = 0;
        m_srun[c] = 0;
      end else begin
        if (m_pos[c] == 0) begin
          if (ch_vld[c]) begin
            m_len[c] = ch_data[c*DATA_W] ? HDR + PLD : HDR;
            m_pos[c] = 1;
            if (m_srun[c] >= SLAT) code = 2;
          end
        end else if (ch_vld[c]) begin
          m_pos[c]++;
          if (m_pos[c] == m_len[c]) begin
            done     = 1;
            m_pos[c] = 0;
          end
        end else begin
          code     = 1;
          m_pos[c] = 0;
        end
        m_srun[c] = ch_stall[c] ? m_srun[c] + 1 : 0;
      end
      if (done && m_cnt[c] == MAXC && code == 0) code = 3;
      if (clr) m_cnt[c] = done ? 1 : 0;
      else if (done && m_cnt[c] < MAXC) m_cnt[c]++;
      if (code != 0) m_sticky[c] = 1'b1;
      else if (clr) m_sticky[c] = 1'b0;
      if (code != 0 && !found) begin
        found = 1; m_err_vld = 1; m_err_ch = c; m_err_code = code;
      end
    end
  endtask

  task automatic tick();
    @(posedge iol2clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge iol2clk);
    #1;
    tests_run++;
    if (pkt_cnt !== '0 || err_vld !== 1'b0 || err_ch !== 3'd0 || err_code !== 2'd0 || err_sticky !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: cnt=%h vld=%b ch=%0d code=%0d sticky=%b, want all 0",
               pkt_cnt, err_vld, err_ch, err_code, err_sticky);
    end
    tests_run++;
    if (pkt_cnt_s !== '0 || err_vld_s !== 1'b0 || err_sticky_s !== '0) begin
      tests_failed++;
      $display("FAIL reset_state_sat: cnt=%h vld=%b sticky=%b, want 0", pkt_cnt_s, err_vld_s, err_sticky_s);
    end
    model_reset();
    rst_l  = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_rd_pkt();
    ch_vld[0] = 1'b1;
    ch_data[0*DATA_W +: DATA_W] = 4'b0110;
    for (int b = 1; b <= HDR; b++) begin
      tick();
      if (b == 2) ch_data[0*DATA_W +: DATA_W] = 4'b1111;
      tests_run++;
      if (err_vld !== 1'b0) begin
        tests_failed++;
        $display("FAIL rd_err_vld beat %0d: got %b want 0", b, err_vld);
      end
      if (b == HDR - 1) begin
        tests_run++;
        if (pkt_cnt[0 +: CNT_W] !== 16'd0) begin
          tests_failed++;
          $display("FAIL rd_cnt_early: got %0d want 0", pkt_cnt[0 +: CNT_W]);
        end
      end
    end
    ch_vld[0] = 1'b0;
    tests_run++;
    if (pkt_cnt[0 +: CNT_W] !== 16'd1) begin
      tests_failed++;
      $display("FAIL rd_cnt: got %0d want 1", pkt_cnt[0 +: CNT_W]);
    end
    tick();
    tests_run++;
    if (err_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_idle_err: got %b want 0", err_vld);
    end
  endtask

  task automatic test_wr_then_rd();
    ch_vld[2] = 1'b1;
    ch_data[2*DATA_W +: DATA_W] = 4'b0001;
    for (int b = 1; b <= HDR + PLD + HDR; b++) begin
      tick();
      ch_data[2*DATA_W +: DATA_W] = 4'b0000;
      tests_run++;
      if (err_vld !== 1'b0) begin
        tests_failed++;
        $display("FAIL wr_err_vld beat %0d: got %b want 0", b, err_vld);
      end
      if (b == HDR) begin
        tests_run++;
        if (pkt_cnt[2*CNT_W +: CNT_W] !== 16'd0) begin
          tests_failed++;
          $display("FAIL wr_cnt_after_hdr: got %0d want 0", pkt_cnt[2*CNT_W +: CNT_W]);
        end
      end
      if (b == HDR + PLD) begin
        tests_run++;
        if (pkt_cnt[2*CNT_W +: CNT_W] !== 16'd1) begin
          tests_failed++;
          $display("FAIL wr_cnt: got %0d want 1", pkt_cnt[2*CNT_W +: CNT_W]);
        end
      end
    end
    ch_vld[2] = 1'b0;
    tests_run++;
    if (pkt_cnt[2*CNT_W +: CNT_W] !== 16'd2) begin
      tests_failed++;
      $display("FAIL wr_rd_cnt: got %0d want 2", pkt_cnt[2*CNT_W +: CNT_W]);
    end
    tick();
  endtask

  task automatic test_gap();
    clr = 1'b1; tick(); clr = 1'b0;
    ch_vld[1] = 1'b1;
    repeat (5) tick();
    ch_vld[1] = 1'b0;
    tick();
    tests_run++;
    if (err_vld !== 1'b1 || err_ch !== 3'd1 || err_code !== 2'd1) begin
      tests_failed++;
      $display("FAIL gap_report: vld=%b ch=%0d code=%0d want 1/1/1", err_vld, err_ch, err_code);
    end
    tests_run++;
    if (err_sticky !== 4'b0010) begin
      tests_failed++;
      $display("FAIL gap_sticky: got %b want 0010", err_sticky);
    end
    tick();
    tests_run++;
    if (err_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_pulse: got %b want 0", err_vld);
    end
  endtask

  task automatic test_stall();
    clr = 1'b1; tick(); clr = 1'b0;
    ch_stall[3] = 1'b1;
    repeat (SLAT) tick();
    ch_stall[3] = 1'b0;
    ch_vld[3]   = 1'b1;
    tick();
    tests_run++;
    if (err_vld !== 1'b1 || err_ch !== 3'd3 || err_code !== 2'd2) begin
      tests_failed++;
      $display("FAIL stall_start: vld=%b ch=%0d code=%0d want 1/3/2", err_vld, err_ch, err_code);
    end
    repeat (HDR - 1) tick();
    ch_vld[3] = 1'b0;
    tests_run++;
    if (pkt_cnt[3*CNT_W +: CNT_W] !== 16'd1) begin
      tests_failed++;
      $display("FAIL stall_pkt_counted: got %0d want 1", pkt_cnt[3*CNT_W +: CNT_W]);
    end
    tick();
    ch_stall[3] = 1'b1;
    tick();
    ch_stall[3] = 1'b0;
    ch_vld[3]   = 1'b1;
    tick();
    tests_run++;
    if (err_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_short: got err_vld %b want 0", err_vld);
    end
    ch_stall[3] = 1'b1;
    repeat (HDR - 1) tick();
    ch_vld[3] = 1'b0;
    ch_stall[3] = 1'b0;
    tests_run++;
    if (err_vld !== 1'b0 || pkt_cnt[3*CNT_W +: CNT_W] !== 16'd2) begin
      tests_failed++;
      $display("FAIL stall_mid_pkt: vld=%b cnt=%0d want 0/2", err_vld, pkt_cnt[3*CNT_W +: CNT_W]);
    end
    tick();
  endtask

  task automatic test_simul_gap();
    clr = 1'b1; tick(); clr = 1'b0;
    ch_vld[2:1] = 2'b11;
    repeat (3) tick();
    ch_vld[2:1] = 2'b00;
    tick();
    tests_run++;
    if (err_vld !== 1'b1 || err_ch !== 3'd1 || err_code !== 2'd1) begin
      tests_failed++;
      $display("FAIL simul_report: vld=%b ch=%0d code=%0d want 1/1/1", err_vld, err_ch, err_code);
    end
    tests_run++;
    if (err_sticky !== 4'b0110) begin
      tests_failed++;
      $display("FAIL simul_sticky: got %b want 0110", err_sticky);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    tests_run++;
    if (err_sticky !== 4'b0000 || pkt_cnt !== '0) begin
      tests_failed++;
      $display("FAIL simul_clr: sticky=%b cnt=%h want 0", err_sticky, pkt_cnt);
    end
  endtask

  task automatic test_clr_coincide();
    ch_vld[0] = 1'b1;
    ch_data[0*DATA_W +: DATA_W] = 4'b0000;
    repeat (HDR) tick();
    ch_vld[1] = 1'b1;
    repeat (HDR - 1) tick();
    ch_vld[1] = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ch_vld[0] = 1'b0;
    tests_run++;
    if (pkt_cnt[0 +: CNT_W] !== 16'd1) begin
      tests_failed++;
      $display("FAIL clr_vs_complete: got %0d want 1", pkt_cnt[0 +: CNT_W]);
    end
    tests_run++;
    if (err_sticky !== 4'b0010 || err_vld !== 1'b1 || err_code !== 2'd1) begin
      tests_failed++;
      $display("FAIL clr_vs_gap: sticky=%b vld=%b code=%0d want 0010/1/1", err_sticky, err_vld, err_code);
    end
    tick();
  endtask

  task automatic test_enable();
    int cnt0;
    cnt0 = m_cnt[0];
    ch_vld[0] = 1'b1;
    ch_stall[3] = 1'b1;
    repeat (5) tick();
    enable = 1'b0;
    tick();
    ch_vld[0] = 1'b0;
    tick();
    tests_run++;
    if (err_vld !== 1'b0 || pkt_cnt[0 +: CNT_W] !== 16'(cnt0)) begin
      tests_failed++;
      $display("FAIL enable_drop: vld=%b cnt=%0d want 0/%0d", err_vld, pkt_cnt[0 +: CNT_W], cnt0);
    end
    enable = 1'b1;
    ch_stall[3] = 1'b0;
    ch_vld[3] = 1'b1;
    tick();
    tests_run++;
    if (err_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_hist_clear: got %b want 0", err_vld);
    end
    repeat (HDR - 1) tick();
    ch_vld[3] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_vld[c]   = ($urandom_range(31) != 0);
        ch_stall[c] = ($urandom_range(2) == 0);
        ch_data[c*DATA_W +: DATA_W] = 4'($urandom_range(15));
      end
      clr    = ($urandom_range(63) == 0);
      enable = ($urandom_range(79) != 0);
      tick();
      tests_run++;
      if (err_vld !== m_err_vld) begin
        tests_failed++;
        $display("FAIL rand_err_vld cyc %0d: got %b want %b", k, err_vld, m_err_vld);
      end
      if (m_err_vld) begin
        tests_run++;
        if (err_ch !== 3'(m_err_ch) || err_code !== 2'(m_err_code)) begin
          tests_failed++;
          $display("FAIL rand_err_info cyc %0d: ch=%0d code=%0d want %0d/%0d",
                   k, err_ch, err_code, m_err_ch, m_err_code);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        tests_run++;
        if (pkt_cnt[c*CNT_W +: CNT_W] !== 16'(m_cnt[c])) begin
          tests_failed++;
          $display("FAIL rand_cnt ch%0d cyc %0d: got %0d want %0d", c, k, pkt_cnt[c*CNT_W +: CNT_W], m_cnt[c]);
        end
      end
      tests_run++;
      if (err_sticky !== m_sticky) begin
        tests_failed++;
        $display("FAIL rand_sticky cyc %0d: got %b want %b", k, err_sticky, m_sticky);
      end
    end
    ch_vld = '0; ch_stall = '0; clr = 1'b0; enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_sat();
    int exp_cnt;
    rst_s = 1'b1;
    tick();
    ch_vld[0] = 1'b1;
    ch_data[0*DATA_W +: DATA_W] = 4'b0000;
    for (int p = 1; p <= 4; p++) begin
      repeat (HDR) tick();
      exp_cnt = (p > 3) ? 3 : p;
      tests_run++;
      if (pkt_cnt_s[1:0] !== 2'(exp_cnt)) begin
        tests_failed++;
        $display("FAIL sat_cnt pkt %0d: got %0d want %0d", p, pkt_cnt_s[1:0], exp_cnt);
      end
      tests_run++;
      if (err_vld_s !== (p == 4)) begin
        tests_failed++;
        $display("FAIL sat_err_vld pkt %0d: got %b want %b", p, err_vld_s, (p == 4));
      end
    end
    tests_run++;
    if (err_code_s !== 2'd3 || err_ch_s !== 3'd0 || err_sticky_s[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_report: code=%0d ch=%0d sticky=%b want 3/0/1", err_code_s, err_ch_s, err_sticky_s);
    end
    repeat (4) tick();
    #2;
    rst_l = 1'b0;
    rst_s = 1'b0;
    #1;
    tests_run++;
    if (pkt_cnt !== '0 || err_vld !== 1'b0 || err_sticky !== '0 ||
        pkt_cnt_s !== '0 || err_vld_s !== 1'b0 || err_sticky_s !== '0 || err_code_s !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: cnt=%h/%h vld=%b/%b sticky=%b/%b, want all 0",
               pkt_cnt, pkt_cnt_s, err_vld, err_vld_s, err_sticky, err_sticky_s);
    end
    model_reset();
    ch_vld = '0;
    #2;
    rst_l = 1'b1;
    rst_s = 1'b1;
    tick();
    tick();
    tests_run++;
    if (err_vld !== 1'b0 || err_vld_s !== 1'b0 || err_sticky !== '0) begin
      tests_failed++;
      $display("FAIL post_reset_no_err: vld=%b/%b sticky=%b want 0", err_vld, err_vld_s, err_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_rd_pkt();
    test_wr_then_rd();
    test_gap();
    test_stall();
    test_simul_gap();
    test_clr_coincide();
    test_enable();
    test_random();
    test_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
